mem_access_unit: RTL and testbench

//  Load/store front end between the CPU MEM stage and datamemory. Accepts one byte/half/word

---
 rtl/mem_access_pkg.sv | 40 ++++
 rtl/mem_access_unit_byte_lane.sv | 47 ++++
 rtl/mem_access_unit.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store front end: op codes, FSM states,
// address window geometry and small decode helpers.
package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [31:0] WINDOW_BYTES     = 32'd4096;
    localparam logic [10:0] STACK_IDX_OFFSET = 11'd1024;

    function automatic logic is_store(input op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_misaligned(input op_e op, input logic [1:0] lo);
        logic bad;
        case (op)
            OP_LH, OP_LHU, OP_SH: bad = lo[0];
            OP_LW, OP_SW:         bad = (lo != 2'd0);
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane.sv
// Combinational lane logic: extracts and extends a byte/half for loads and
// merges store data into the fetched word for read-modify-write stores.
module mem_byte_lane
    import mem_access_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Little-endian lane select and load extension.
    always_comb begin
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_data = {24'd0, byte_v};
            OP_LH:   load_data = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_data = {16'd0, half_v};
            default: load_data = word;
        endcase
    end

    // Store merge: only the addressed lane of the fetched word is replaced.
    always_comb begin
        merged = word;
        case (op)
            OP_SB: merged[{lane, 3'b000} +: 8] = wdata[7:0];
            OP_SH: begin
                if (lane[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            OP_SW:   merged = wdata;
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end between the CPU MEM stage and the word-addressed data
// memory: decodes the byte address, checks it, and sequences read/write strobes.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter logic [31:0] GLOBAL_BASE = 32'h1001_0000,
    parameter logic [31:0] STACK_BASE  = 32'h7FFF_E000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        ready,
    input  logic [2:0]  op,
    input  logic [31:0] vaddr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err_align,
    output logic        err_range,
    output logic [10:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_mwrite,
    output logic        mem_mread,
    input  logic [31:0] mem_rdata
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_align_q, err_align_d;
    logic        err_range_q, err_range_d;
    logic [10:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_mwrite_q, mem_mwrite_d;
    logic        mem_mread_q, mem_mread_d;

    logic [31:0] g_off, s_off;
    logic        in_g, in_s, misaligned;
    logic [10:0] idx;
    logic [31:0] load_data, merged;

    // The fetched word goes straight from the read port into the lane logic.
    mem_byte_lane u_lane (
        .op        (op_q),
        .lane      (lane_q),
        .word      (mem_rdata),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // Address decode; unsigned offset compare covers both window bounds at once.
    always_comb begin
        g_off      = vaddr - GLOBAL_BASE;
        s_off      = vaddr - STACK_BASE;
        in_g       = (g_off < WINDOW_BYTES);
        in_s       = (s_off < WINDOW_BYTES);
        misaligned = is_misaligned(op_e'(op), vaddr[1:0]);
        if (in_g) begin
            idx = {1'b0, g_off[11:2]};
        end else if (in_s) begin
            idx = STACK_IDX_OFFSET + {1'b0, s_off[11:2]};
        end else begin
            idx = 11'd0;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        ready_d      = ready_q;
        done_d       = 1'b0;
        rdata_d      = rdata_q;
        err_align_d  = err_align_q;
        err_range_d  = err_range_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_mwrite_d = 1'b0;
        mem_mread_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req && ready_q) begin
                    op_d    = op_e'(op);
                    lane_d  = vaddr[1:0];
                    wdata_d = wdata;
                    ready_d = 1'b0;
                    if (misaligned || !(in_g || in_s)) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        rdata_d     = 32'd0;
                        err_align_d = misaligned;
                        err_range_d = !(in_g || in_s);
                    end else begin
                        state_d     = ST_READ;
                        mem_mread_d = 1'b1;
                        mem_addr_d  = idx;
                    end
                end else begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            ST_READ: begin
                if (is_store(op_q)) begin
                    state_d      = ST_WRITE;
                    mem_mwrite_d = 1'b1;
                    mem_wdata_d  = merged;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    rdata_d = load_data;
                end
            end
            ST_WRITE: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                rdata_d = 32'd0;
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                ready_d     = 1'b1;
                err_align_d = 1'b0;
                err_range_d = 1'b0;
            end
            default: begin
                state_d     = ST_IDLE;
                ready_d     = 1'b1;
                err_align_d = 1'b0;
                err_range_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_LB;
            lane_q       <= 2'd0;
            wdata_q      <= 32'd0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            rdata_q      <= 32'd0;
            err_align_q  <= 1'b0;
            err_range_q  <= 1'b0;
            mem_addr_q   <= 11'd0;
            mem_wdata_q  <= 32'd0;
            mem_mwrite_q <= 1'b0;
            mem_mread_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            err_align_q  <= err_align_d;
            err_range_q  <= err_range_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_mwrite_q <= mem_mwrite_d;
            mem_mread_q  <= mem_mread_d;
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign err_align = err_align_q;
    assign err_range = err_range_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_mread = mem_mread_q;
    // A reset landing on the write cycle must suppress the write in that same cycle.
    assign mem_mwrite = mem_mwrite_q & ~rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a 2048-word memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        ready;
    logic [2:0]  op;
    logic [31:0] vaddr;
    logic [31:0] wdata;
    logic        done;
    logic [31:0] rdata;
    logic        err_align;
    logic        err_range;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_mwrite;
    logic        mem_mread;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:2047];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    int          done_cnt = 0;
    logic [10:0] rd_addr = 11'd0;
    logic [10:0] wr_addr = 11'd0;
    logic [31:0] wr_data = 32'd0;

    mem_access_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ready      (ready),
        .op         (op),
        .vaddr      (vaddr),
        .wdata      (wdata),
        .done       (done),
        .rdata      (rdata),
        .err_align  (err_align),
        .err_range  (err_range),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mwrite (mem_mwrite),
        .mem_mread  (mem_mread),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_mwrite) mem[mem_addr] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_mread) begin
            rd_cnt  = rd_cnt + 1;
            rd_addr = mem_addr;
        end
        if (mem_mwrite) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = mem_addr;
            wr_data = mem_wdata;
        end
        if (mem_mread && mem_mwrite) both_cnt = both_cnt + 1;
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat, output logic ea,
                          output logic er, output int nrd, output int nwr);
        int rd0;
        int wr0;
        @(negedge clk);
        chk("ready_before_req", {31'd0, ready}, 32'd1);
        rd0   = rd_cnt;
        wr0   = wr_cnt;
        req   = 1'b1;
        op    = o;
        vaddr = a;
        wdata = d;
        @(posedge clk);
        #1;
        req   = 1'b0;
        op    = 3'd7;
        vaddr = 32'h1001_0000;
        wdata = 32'hFFFF_FFFF;
        lat = 0;
        rd  = 32'hXXXX_XXXX;
        ea  = 1'bx;
        er  = 1'bx;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                rd  = rdata;
                ea  = err_align;
                er  = err_range;
                break;
            end
        end
        if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
        nrd = rd_cnt - rd0;
        nwr = wr_cnt - wr0;
    endtask

    initial begin
        logic [31:0] r;
        int          lat;
        logic        ea;
        logic        er;
        int          nr;
        int          nw;
        int          dc0;

        for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
        rst = 1'b1; req = 1'b0; op = 3'd0; vaddr = 32'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_errs", {30'd0, err_align, err_range}, 32'd0);
        chk("rst_strobes", {30'd0, mem_mread, mem_mwrite}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_addr", {21'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        // SW then LW at the same global address
        access(3'd7, 32'h1001_0008, 32'hDEAD_BEEF, r, lat, ea, er, nr, nw);
        chk("sw_lat", lat, 32'd3);
        chk("sw_wr_addr", {21'd0, wr_addr}, 32'd2);
        chk("sw_wr_data", wr_data, 32'hDEAD_BEEF);
        chk("sw_strobes", {nr[15:0], nw[15:0]}, {16'd1, 16'd1});
        chk("sw_rdata", r, 32'd0);
        chk("sw_errs", {30'd0, ea, er}, 32'd0);
        chk("sw_mem", mem[2], 32'hDEAD_BEEF);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);

        access(3'd2, 32'h1001_0008, 32'd0, r, lat, ea, er, nr, nw);
        chk("lw_lat", lat, 32'd2);
        chk("lw_rdata", r, 32'hDEAD_BEEF);
        chk("lw_rd_addr", {21'd0, rd_addr}, 32'd2);
        chk("lw_strobes", {nr[15:0], nw[15:0]}, {16'd1, 16'd0});

        // SB into the stack window, then signed/unsigned byte loads
        mem[1025] = 32'h1122_3344;
        access(3'd5, 32'h7FFF_E005, 32'h1234_5680, r, lat, ea, er, nr, nw);
        chk("sb_lat", lat, 32'd3);
        chk("sb_wr_addr", {21'd0, wr_addr}, 32'd1025);
        chk("sb_wr_data", wr_data, 32'h1122_8044);
        chk("sb_rdata", r, 32'd0);
        access(3'd0, 32'h7FFF_E005, 32'd0, r, lat, ea, er, nr, nw);
        chk("lb_rdata", r, 32'hFFFF_FF80);
        access(3'd3, 32'h7FFF_E005, 32'd0, r, lat, ea, er, nr, nw);
        chk("lbu_rdata", r, 32'h0000_0080);

        // SH upper half, then signed/unsigned half loads
        access(3'd6, 32'h1001_0002, 32'h0000_ABCD, r, lat, ea, er, nr, nw);
        chk("sh_wr_data", wr_data, 32'hABCD_0000);
        chk("sh_wr_addr", {21'd0, wr_addr}, 32'd0);
        access(3'd1, 32'h1001_0002, 32'd0, r, lat, ea, er, nr, nw);
        chk("lh_rdata", r, 32'hFFFF_ABCD);
        access(3'd4, 32'h1001_0002, 32'd0, r, lat, ea, er, nr, nw);
        chk("lhu_rdata", r, 32'h0000_ABCD);

        // Error paths: no strobes, done one cycle after accept
        access(3'd2, 32'h1001_0001, 32'd0, r, lat, ea, er, nr, nw);
        chk("align_lat", lat, 32'd1);
        chk("align_flags", {30'd0, ea, er}, 32'd2);
        chk("align_strobes", {nr[15:0], nw[15:0]}, 32'd0);
        chk("align_rdata", r, 32'd0);
        access(3'd2, 32'h2000_0000, 32'd0, r, lat, ea, er, nr, nw);
        chk("range_flags", {30'd0, ea, er}, 32'd1);
        chk("range_strobes", {nr[15:0], nw[15:0]}, 32'd0);
        access(3'd1, 32'h2000_0001, 32'd0, r, lat, ea, er, nr, nw);
        chk("both_flags", {30'd0, ea, er}, 32'd3);
        access(3'd7, 32'h1001_0002, 32'h1, r, lat, ea, er, nr, nw);
        chk("sw_align_flags", {30'd0, ea, er}, 32'd2);
        chk("sw_align_strobes", {nr[15:0], nw[15:0]}, 32'd0);

        // Window boundaries
        mem[1023] = 32'hCAFE_F00D;
        access(3'd2, 32'h1001_0FFC, 32'd0, r, lat, ea, er, nr, nw);
        chk("g_top_addr", {21'd0, rd_addr}, 32'd1023);
        chk("g_top_rdata", r, 32'hCAFE_F00D);
        access(3'd2, 32'h1001_1000, 32'd0, r, lat, ea, er, nr, nw);
        chk("g_end_range", {30'd0, ea, er}, 32'd1);
        access(3'd2, 32'h1000_FFFC, 32'd0, r, lat, ea, er, nr, nw);
        chk("g_below_range", {30'd0, ea, er}, 32'd1);
        mem[2047] = 32'h0BAD_C0DE;
        access(3'd2, 32'h7FFF_EFFC, 32'd0, r, lat, ea, er, nr, nw);
        chk("s_top_addr", {21'd0, rd_addr}, 32'd2047);
        chk("s_top_rdata", r, 32'h0BAD_C0DE);
        access(3'd2, 32'h7FFF_DFFC, 32'd0, r, lat, ea, er, nr, nw);
        chk("s_below_range", {30'd0, ea, er}, 32'd1);

        // req held high across DONE is accepted again in the following IDLE
        @(negedge clk);
        req = 1'b1; op = 3'd2; vaddr = 32'h2000_0000;
        @(posedge clk);
        @(negedge clk);
        chk("hold_done1", {31'd0, done}, 32'd1);
        chk("hold_ready_busy", {31'd0, ready}, 32'd0);
        @(negedge clk);
        chk("hold_gap", {30'd0, done, ready}, 32'd1);
        @(negedge clk);
        chk("hold_done2", {31'd0, done}, 32'd1);
        req = 1'b0;
        @(negedge clk);
        chk("hold_idle", {30'd0, done, ready}, 32'd1);

        // Reset landing on the write cycle of an SB
        mem[5] = 32'h5566_7788;
        @(negedge clk);
        dc0 = done_cnt;
        req = 1'b1; op = 3'd5; vaddr = 32'h1001_0014; wdata = 32'h0000_00AA;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rstw_mwrite", {31'd0, mem_mwrite}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstw_ready", {31'd0, ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("rstw_no_done", done_cnt, dc0);
        chk("rstw_mem", mem[5], 32'h5566_7788);

        chk("never_both_strobes", both_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
